// File: rtl/dmem_arb_defs_pkg.sv
// rtl/dmem_arb_defs_pkg.sv - shared encodings for the data-memory arbiter
// Purpose: FSM state encoding, access owner encoding and the wait-counter
//          width used by dmem_arbiter and wait_counter.
// Ports:   none (package).
`ifndef DMEM_ARB_DEFS_SV
`define DMEM_ARB_DEFS_SV

package dmem_arb_defs;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_LD   = 1'b1
  } owner_t;

endpackage

`endif

// File: rtl/dmem_arbiter_wait_counter.sv
// rtl/dmem_arbiter_wait_counter.sv - loadable down-counter for access wait states
// Purpose: holds the remaining wait cycles of the access in flight.
// Ports:   clk, rst_n (async, active-low)
//          load, load_val : load a new count (takes priority over dec)
//          dec            : count down by one, stopping at zero
//          count          : current value
//          done           : high while count==1, the completion cycle
module wait_counter
  import dmem_arb_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter (pipeline vs loader)
// Purpose: shares the data memory between the MEM stage and a loader/debug
//          port, inserting WAIT_CYCLES wait states per access and stalling
//          the pipeline while its request is not being completed.
// Ports:   CLK, RST_N (async, active-low)
//          MemWriteM/MemtoRegM/ALUOutM/WriteDataM : pipeline request
//          StallM, ReadDataM                      : pipeline response
//          LdValid/LdWrite/LdAddr/LdWData         : loader request
//          LdReady, LdRData                       : loader response
//          MemA/MemWD/MemWE, MemRD                : memory port
// Config:  DMEM_ARB_FAIRNESS_EN enables the loader starvation guard
//          (STARVE_LIMIT consecutive contested pipeline grants).
module dmem_arbiter
  import dmem_arb_defs::*;
#(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  input  logic        LdValid,
  input  logic        LdWrite,
  input  logic [31:0] LdAddr,
  input  logic [31:0] LdWData,
  output logic        LdReady,
  output logic [31:0] LdRData,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD
);

  localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(WAIT_CYCLES);
  localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t           state, state_nxt;
  owner_t           own_q;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  logic             idle, preq, force_ld;
  logic             grant, grant_ld, grant_pipe;
  logic             g_write;
  logic [31:0]      g_addr, g_wdata;
  logic             done_now, cur_write, pipe_done, ld_done;
  owner_t           cur_owner;

  assign idle = (state == IDLE);
  assign preq = MemWriteM | MemtoRegM;

  // Pipeline wins every contest unless the starvation guard forces the loader.
  assign grant_ld   = idle & LdValid & (~preq | force_ld);
  assign grant_pipe = idle & preq & ~grant_ld;
  assign grant      = grant_ld | grant_pipe;

  // A request with both MemWriteM and MemtoRegM set is treated as a store.
  assign g_write = grant_ld ? LdWrite : MemWriteM;
  assign g_addr  = grant_ld ? LdAddr  : ALUOutM;
  assign g_wdata = grant_ld ? LdWData : WriteDataM;

  // With zero wait states the grant cycle is also the completion cycle.
  assign done_now  = (grant & ZERO_WAIT) | (~idle & cnt_done);
  assign cur_owner = idle ? (grant_ld ? OWN_LD : OWN_PIPE) : own_q;
  assign cur_write = idle ? g_write : we_q;
  assign pipe_done = done_now & (cur_owner == OWN_PIPE);
  assign ld_done   = done_now & (cur_owner == OWN_LD);

`ifdef DMEM_ARB_FAIRNESS_EN
  logic [CNT_W-1:0] streak;

  assign force_ld = (streak == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      streak <= '0;
    end else if (idle) begin
      if (grant_ld || !LdValid) begin
        streak <= '0;
      end else if (grant_pipe) begin
        streak <= streak + 1'b1;
      end
    end
  end
`else
  // Strict pipeline priority: false for every legal STARVE_LIMIT (1..15).
  assign force_ld = (STARVE_LIMIT < 1);
`endif

  wait_counter u_wait_counter (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (grant),
    .load_val (WAIT_LD),
    .dec      (~idle),
    .count    (cnt),
    .done     (cnt_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      own_q   <= OWN_PIPE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        own_q   <= grant_ld ? OWN_LD : OWN_PIPE;
        we_q    <= g_write;
        addr_q  <= g_addr;
        wdata_q <= g_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    ReadDataM = '0;
    LdReady   = 1'b0;
    LdRData   = '0;
    MemA      = '0;
    MemWD     = '0;
    MemWE     = 1'b0;

    case (state)
      IDLE:    if (grant && !ZERO_WAIT) state_nxt = ACCESS;
      ACCESS:  if (cnt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are forced to their reset values while reset is asserted so an
    // access cut off by reset never commits a write.
    if (RST_N) begin
      if (grant) begin
        MemA  = g_addr;
        MemWD = g_wdata;
      end else if (!idle) begin
        MemA  = addr_q;
        MemWD = wdata_q;
      end
      MemWE  = done_now & cur_write;
      StallM = preq & ~pipe_done;
      if (pipe_done && !cur_write) ReadDataM = MemRD;
      if (ld_done) begin
        LdReady = 1'b1;
        LdRData = MemRD;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: WAIT_CYCLES=2
  logic        a_mw = 0, a_mr = 0, a_lv = 0, a_lw = 0;
  logic [31:0] a_addr = 0, a_wd = 0, a_la = 0, a_lwd = 0;
  logic        a_stall, a_ldr, a_we;
  logic [31:0] a_rd, a_ldrd, a_mema, a_memwd, a_memrd;
  logic [31:0] mem_a [0:63];

  // Instance B: WAIT_CYCLES=0
  logic        b_mw = 0, b_mr = 0, b_lv = 0, b_lw = 0;
  logic [31:0] b_addr = 0, b_wd = 0, b_la = 0, b_lwd = 0;
  logic        b_stall, b_ldr, b_we;
  logic [31:0] b_rd, b_ldrd, b_mema, b_memwd, b_memrd;
  logic [31:0] mem_b [0:63];

  dmem_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(2)) u_a (
    .CLK(CLK), .RST_N(RST_N),
    .MemWriteM(a_mw), .MemtoRegM(a_mr), .ALUOutM(a_addr), .WriteDataM(a_wd),
    .StallM(a_stall), .ReadDataM(a_rd),
    .LdValid(a_lv), .LdWrite(a_lw), .LdAddr(a_la), .LdWData(a_lwd),
    .LdReady(a_ldr), .LdRData(a_ldrd),
    .MemA(a_mema), .MemWD(a_memwd), .MemWE(a_we), .MemRD(a_memrd)
  );

  dmem_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(2)) u_b (
    .CLK(CLK), .RST_N(RST_N),
    .MemWriteM(b_mw), .MemtoRegM(b_mr), .ALUOutM(b_addr), .WriteDataM(b_wd),
    .StallM(b_stall), .ReadDataM(b_rd),
    .LdValid(b_lv), .LdWrite(b_lw), .LdAddr(b_la), .LdWData(b_lwd),
    .LdReady(b_ldr), .LdRData(b_ldrd),
    .MemA(b_mema), .MemWD(b_memwd), .MemWE(b_we), .MemRD(b_memrd)
  );

  assign a_memrd = mem_a[a_mema[7:2]];
  assign b_memrd = mem_b[b_mema[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] <= 32'h0;
      mem_b[i] <= 32'h0;
    end
    mem_a[32] <= 32'hA5A5A5A5;
    mem_b[8]  <= 32'h12345678;
  end

  always @(posedge CLK) begin
    if (a_we) mem_a[a_mema[7:2]] <= a_memwd;
    if (b_we) mem_b[b_mema[7:2]] <= b_memwd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mw, mr;
    logic [31:0] addr, wd;
    logic        lv, lw;
    logic [31:0] la, lwd;
    logic        e_stall, e_we;
    logic [31:0] e_a, e_wd, e_rd;
    logic        e_ldr;
    logic [31:0] e_ldrd;
  } vec_t;

  vec_t vecs [8];

  // One pipeline access on instance A: drives the request, checks the
  // three cycles (grant, wait, completion) and releases the request.
  task automatic a_pipe(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    @(negedge CLK);
    a_mw = wr; a_mr = ~wr; a_addr = addr; a_wd = wd;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge CLK);
      #1;
      chk($sformatf("a_pipe stall c%0d", c), {31'd0, a_stall}, {31'd0, (c < 2)});
      chk($sformatf("a_pipe we c%0d", c), {31'd0, a_we}, {31'd0, (wr && c == 2)});
      if (c == 2 && !wr) chk("a_pipe rdata", a_rd, exp_rd);
    end
    @(negedge CLK);
    a_mw = 0; a_mr = 0;
  endtask

  logic [1:0] exp_grant [6];
  logic [1:0] got_grant;
  int         cnt;

  initial begin
    vecs[0] = '{0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0,0,32'h0};
    vecs[1] = '{0,1,32'h20,32'h0, 0,0,32'h0,32'h0, 0,0,32'h20,32'h0,32'h12345678,0,32'h0};
    vecs[2] = '{1,0,32'h24,32'hCAFEF00D, 0,0,32'h0,32'h0, 0,1,32'h24,32'hCAFEF00D,32'h0,0,32'h0};
    vecs[3] = '{0,1,32'h24,32'h0, 0,0,32'h0,32'h0, 0,0,32'h24,32'h0,32'hCAFEF00D,0,32'h0};
    vecs[4] = '{0,0,32'h0,32'h0, 1,1,32'h30,32'h55AA55AA, 0,1,32'h30,32'h55AA55AA,32'h0,1,32'h0};
    vecs[5] = '{0,0,32'h0,32'h0, 1,0,32'h30,32'h0, 0,0,32'h30,32'h0,32'h0,1,32'h55AA55AA};
    vecs[6] = '{0,1,32'h20,32'h0, 1,0,32'h30,32'h0, 0,0,32'h20,32'h0,32'h12345678,0,32'h0};
    vecs[7] = '{1,1,32'h28,32'h0BADC0DE, 0,0,32'h0,32'h0, 0,1,32'h28,32'h0BADC0DE,32'h0,0,32'h0};

`ifdef DMEM_ARB_FAIRNESS_EN
    exp_grant = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
`else
    exp_grant = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst stall", {31'd0, a_stall}, 32'd0);
    chk("rst we", {31'd0, a_we}, 32'd0);
    chk("rst mema", a_mema, 32'd0);
    chk("rst memwd", a_memwd, 32'd0);
    chk("rst rdata", a_rd, 32'd0);
    chk("rst ldready", {31'd0, a_ldr}, 32'd0);
    chk("rst ldrdata", a_ldrd, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Zero-wait-state vectors on instance B
    foreach (vecs[i]) begin
      @(negedge CLK);
      b_mw = vecs[i].mw; b_mr = vecs[i].mr; b_addr = vecs[i].addr; b_wd = vecs[i].wd;
      b_lv = vecs[i].lv; b_lw = vecs[i].lw; b_la = vecs[i].la; b_lwd = vecs[i].lwd;
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, b_stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d we", i), {31'd0, b_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d mema", i), b_mema, vecs[i].e_a);
      chk($sformatf("v%0d memwd", i), b_memwd, vecs[i].e_wd);
      chk($sformatf("v%0d rdata", i), b_rd, vecs[i].e_rd);
      chk($sformatf("v%0d ldready", i), {31'd0, b_ldr}, {31'd0, vecs[i].e_ldr});
      chk($sformatf("v%0d ldrdata", i), b_ldrd, vecs[i].e_ldrd);
    end
    @(negedge CLK);
    b_mw = 0; b_mr = 0; b_lv = 0; b_lw = 0;

    // Continuous contested traffic on instance B
    @(negedge CLK);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      b_mr = 1; b_addr = 32'h20; b_lv = 1; b_lw = 0; b_la = 32'h30;
      #1;
      got_grant = b_ldr ? 2'd2 : (!b_stall ? 2'd1 : 2'd0);
      chk($sformatf("fair grant %0d", k), {30'd0, got_grant}, {30'd0, exp_grant[k]});
    end
    @(negedge CLK);
    b_mr = 0; b_lv = 0;

    // Store then load with two wait states on instance A
    a_pipe(1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    a_pipe(1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Loader write in flight, pipeline load of the same address arrives
    @(negedge CLK);
    a_lv = 1; a_lw = 1; a_la = 32'h40; a_lwd = 32'h11223344;
    #1;
    chk("ld grant stall", {31'd0, a_stall}, 32'd0);
    chk("ld grant mema", a_mema, 32'h40);
    @(negedge CLK);
    a_mr = 1; a_addr = 32'h40;
    #1;
    chk("ld held stall", {31'd0, a_stall}, 32'd1);
    cnt = 0;
    while (!a_ldr && cnt < 10) begin
      @(negedge CLK);
      #1;
      cnt++;
    end
    chk("ld ready seen", {31'd0, a_ldr}, 32'd1);
    chk("ld ready stall", {31'd0, a_stall}, 32'd1);
    chk("ld ready we", {31'd0, a_we}, 32'd1);
    @(negedge CLK);
    a_lv = 0;
    #1;
    cnt = 1;
    while (a_stall && cnt < 20) begin
      @(negedge CLK);
      #1;
      cnt++;
    end
    chk("ld then pipe stall cycles", cnt, 32'd3);
    chk("ld then pipe rdata", a_rd, 32'h11223344);
    @(negedge CLK);
    a_mr = 0;

    // Reset in the completion cycle of a store
    @(negedge CLK);
    a_mw = 1; a_addr = 32'h80; a_wd = 32'h99999999;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rstmid we before", {31'd0, a_we}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rstmid we", {31'd0, a_we}, 32'd0);
    chk("rstmid stall", {31'd0, a_stall}, 32'd0);
    chk("rstmid mema", a_mema, 32'd0);
    chk("rstmid memwd", a_memwd, 32'd0);
    chk("rstmid rdata", a_rd, 32'd0);
    chk("rstmid ldready", {31'd0, a_ldr}, 32'd0);
    @(posedge CLK);
    #1;
    chk("rstmid mem unchanged", mem_a[32], 32'hA5A5A5A5);
    @(negedge CLK);
    a_mw = 0;
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    chk("post rst idle stall", {31'd0, a_stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
